// File: rtl/sprite_pkg.sv
// Shared types for the sprite table scanner: table entry layout, scan FSM states
// and the vertical hit test used by the scanner.
package sprite_pkg;

   localparam int SPRITE_Y_W        = 10;
   localparam int SPRITE_TBL_ADDR_W = 9;

   typedef struct packed {
      logic                  en;
      logic [6:0]            img;
      logic [9:0]            x;
      logic [SPRITE_Y_W-1:0] y;
      logic [3:0]            pal;
   } sprite_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      LAST,
      DONE
   } scan_state_t;

   // Wrapping 10-bit subtraction so sprites parked near line 1023 continue onto line 0.
   function automatic logic sprite_hit(input sprite_entry_t e,
                                       input logic [SPRITE_Y_W-1:0] line_y,
                                       input int height);
      logic [SPRITE_Y_W-1:0] diff;
      diff = line_y - e.y;
      return e.en && (int'(diff) < height);
   endfunction

endpackage

// File: rtl/sprite_line_list.sv
// Per-line sprite hit list: bank storage, write pointer and HIT_COUNT.
// With SPRITE_LIST_DBL_BUF_EN defined, a back bank is filled while the front bank is read.
module sprite_line_list
   import sprite_pkg::*;
#(
   parameter int MAX_PER_LINE = 8
) (
   input  logic                              CLK,
   input  logic                              RESETn,
   input  logic                              clear,
   input  logic                              wr_en,
   input  logic [31:0]                       wr_data,
   input  logic                              swap,
   input  logic [$clog2(MAX_PER_LINE)-1:0]   rd_idx,
   output logic [31:0]                       rd_data,
   output logic [$clog2(MAX_PER_LINE+1)-1:0] hit_count,
   output logic                              full
);

   localparam int IDX_W = $clog2(MAX_PER_LINE);
   localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

`ifdef SPRITE_LIST_DBL_BUF_EN

   logic [31:0]      bank_q [2][MAX_PER_LINE];
   logic [CNT_W-1:0] cnt_q  [2];
   logic             back_q;

   // The scan only ever touches the back bank; the swap hands it to the renderer.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         for (int b = 0; b < 2; b++) begin
            cnt_q[b] <= '0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
               bank_q[b][i] <= '0;
            end
         end
         back_q <= 1'b0;
      end else begin
         if (clear) begin
            cnt_q[back_q] <= '0;
         end else if (wr_en) begin
            bank_q[back_q][cnt_q[back_q][IDX_W-1:0]] <= wr_data;
            cnt_q[back_q] <= cnt_q[back_q] + 1'b1;
         end
         if (swap) begin
            back_q <= ~back_q;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < MAX_PER_LINE) begin
         rd_data = bank_q[~back_q][rd_idx];
      end
   end

   assign hit_count = cnt_q[~back_q];
   assign full      = (cnt_q[back_q] == CNT_W'(MAX_PER_LINE));

`else

   logic [31:0]      bank_q [MAX_PER_LINE];
   logic [CNT_W-1:0] cnt_q;
   logic             unused_swap;

   assign unused_swap = swap;

   // Single bank: the renderer sees entries appear live as the scan finds them.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt_q <= '0;
         for (int i = 0; i < MAX_PER_LINE; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         if (clear) begin
            cnt_q <= '0;
         end else if (wr_en) begin
            bank_q[cnt_q[IDX_W-1:0]] <= wr_data;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < MAX_PER_LINE) begin
         rd_data = bank_q[rd_idx];
      end
   end

   assign hit_count = cnt_q;
   assign full      = (cnt_q == CNT_W'(MAX_PER_LINE));

`endif

endmodule

// File: rtl/sprite_table_scanner.sv
// Walks the sprite table on each line start and collects sprites covering LINE_Y.
// Optional double-buffered hit list via SPRITE_LIST_DBL_BUF_EN.
module sprite_table_scanner
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES  = 64,
   parameter int SPRITE_H     = 16,
   parameter int MAX_PER_LINE = 8
) (
   input  logic                              CLK,
   input  logic                              RESETn,
   input  logic                              LINE_START,
   input  logic [9:0]                        LINE_Y,
   output logic [8:0]                        SPRITE_TABLE_RD_ADDR,
   input  logic [31:0]                       SPRITE_TABLE_DO,
   input  logic [$clog2(MAX_PER_LINE)-1:0]   LIST_RD_IDX,
   output logic [31:0]                       LIST_RD_DATA,
   output logic [$clog2(MAX_PER_LINE+1)-1:0] HIT_COUNT,
   output logic                              SCAN_BUSY,
   output logic                              SCAN_DONE,
   output logic                              OVERFLOW
);

   scan_state_t                  state_q, state_d;
   logic [SPRITE_TBL_ADDR_W-1:0] addr_q;
   logic [SPRITE_Y_W-1:0]        line_y_q;
   logic                         valid_q;
   logic                         overflow_q;

   sprite_entry_t entry;
   logic          hit;
   logic          full;
   logic          start;
   logic          addr_inc;
   logic          wr_en;
   logic          set_ovf;
   logic          swap;
   logic          last_addr;

   assign entry     = SPRITE_TABLE_DO;
   assign hit       = valid_q && sprite_hit(entry, line_y_q, SPRITE_H);
   assign last_addr = (addr_q == SPRITE_TBL_ADDR_W'(NUM_SPRITES - 1));

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A LINE_START in any state restarts the walk; a full list cuts the scan short.
   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      addr_inc = 1'b0;
      wr_en    = 1'b0;
      set_ovf  = 1'b0;
      if (LINE_START) begin
         start   = 1'b1;
         state_d = READ;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            READ: begin
               if (hit && full) begin
                  set_ovf = 1'b1;
                  state_d = DONE;
               end else begin
                  wr_en = hit;
                  if (last_addr) begin
                     state_d = LAST;
                  end else begin
                     addr_inc = 1'b1;
                  end
               end
            end
            LAST: begin
               set_ovf = hit && full;
               wr_en   = hit && !full;
               state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      swap = (state_d == DONE) && (state_q != DONE);
   end

   // Data returned while not in READ (or on the abort cycle) belongs to a stale address.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         addr_q     <= '0;
         line_y_q   <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         valid_q <= (state_q == READ) && !start;
         if (start) begin
            addr_q     <= '0;
            line_y_q   <= LINE_Y;
            overflow_q <= 1'b0;
         end else begin
            if (addr_inc) begin
               addr_q <= addr_q + 1'b1;
            end
            if (set_ovf) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   sprite_line_list #(
      .MAX_PER_LINE(MAX_PER_LINE)
   ) u_list (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .clear    (start),
      .wr_en    (wr_en),
      .wr_data  (SPRITE_TABLE_DO),
      .swap     (swap),
      .rd_idx   (LIST_RD_IDX),
      .rd_data  (LIST_RD_DATA),
      .hit_count(HIT_COUNT),
      .full     (full)
   );

   assign SPRITE_TABLE_RD_ADDR = addr_q;
   assign SCAN_BUSY            = (state_q == READ) || (state_q == LAST);
   assign SCAN_DONE            = (state_q == DONE);
   assign OVERFLOW             = overflow_q;

endmodule

// File: tb/tb_sprite_table_scanner.sv
// Directed, table-driven bench for sprite_table_scanner with a synchronous RAM model.
// Also exercises the double-buffered list when SPRITE_LIST_DBL_BUF_EN is defined.
module tb_sprite_table_scanner;

   logic        CLK;
   logic        RESETn;
   logic        LINE_START;
   logic [9:0]  LINE_Y;
   logic [8:0]  SPRITE_TABLE_RD_ADDR;
   logic [31:0] SPRITE_TABLE_DO;
   logic [2:0]  LIST_RD_IDX;
   logic [31:0] LIST_RD_DATA;
   logic [3:0]  HIT_COUNT;
   logic        SCAN_BUSY;
   logic        SCAN_DONE;
   logic        OVERFLOW;

   logic [31:0] mem [512];

   int total = 0;
   int bad   = 0;

   sprite_table_scanner #(
      .NUM_SPRITES (64),
      .SPRITE_H    (16),
      .MAX_PER_LINE(8)
   ) dut (
      .CLK                 (CLK),
      .RESETn              (RESETn),
      .LINE_START          (LINE_START),
      .LINE_Y              (LINE_Y),
      .SPRITE_TABLE_RD_ADDR(SPRITE_TABLE_RD_ADDR),
      .SPRITE_TABLE_DO     (SPRITE_TABLE_DO),
      .LIST_RD_IDX         (LIST_RD_IDX),
      .LIST_RD_DATA        (LIST_RD_DATA),
      .HIT_COUNT           (HIT_COUNT),
      .SCAN_BUSY           (SCAN_BUSY),
      .SCAN_DONE           (SCAN_DONE),
      .OVERFLOW            (OVERFLOW)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) SPRITE_TABLE_DO <= mem[SPRITE_TABLE_RD_ADDR];

   typedef struct {
      logic       en;
      logic [9:0] y;
      logic [9:0] line;
      logic       hit;
   } vec_t;

   function automatic logic [31:0] mk(input logic en, input logic [6:0] img,
                                      input logic [9:0] x, input logic [9:0] y,
                                      input logic [3:0] pal);
      return {en, img, x, y, pal};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clearTable();
      for (int i = 0; i < 512; i++) mem[i] = '0;
   endtask

   task automatic applyStimulus(input logic [9:0] y);
      @(negedge CLK);
      LINE_Y     = y;
      LINE_START = 1'b1;
      @(posedge CLK);
      #1 LINE_START = 1'b0;
   endtask

   // Runs a fixed window after a start; cycle c is the negedge of the c-th cycle after sampling.
   task automatic waitDone(output int doneCyc, output int doneCnt, output int addrErr);
      doneCyc = -1;
      doneCnt = 0;
      addrErr = 0;
      for (int c = 1; c <= 70; c++) begin
         @(negedge CLK);
         if (c <= 64 && SPRITE_TABLE_RD_ADDR !== 9'(c - 1)) addrErr++;
         if (SCAN_DONE === 1'b1) begin
            doneCnt++;
            if (doneCyc < 0) doneCyc = c;
         end
      end
   endtask

   function automatic logic [31:0] readList(input int idx);
      return 32'(idx);
   endfunction

   task automatic readEntry(input int idx, output logic [31:0] d);
      LIST_RD_IDX = 3'(idx);
      #1 d = LIST_RD_DATA;
   endtask

   vec_t vecs [9];
   int doneCyc, doneCnt, addrErr;
   logic [31:0] d;

   initial begin
      vecs[0] = '{1'b1, 10'd100,  10'd100,  1'b1};
      vecs[1] = '{1'b1, 10'd85,   10'd100,  1'b1};
      vecs[2] = '{1'b1, 10'd84,   10'd100,  1'b0};
      vecs[3] = '{1'b1, 10'd101,  10'd100,  1'b0};
      vecs[4] = '{1'b0, 10'd100,  10'd100,  1'b0};
      vecs[5] = '{1'b1, 10'd1020, 10'd5,    1'b1};
      vecs[6] = '{1'b1, 10'd1014, 10'd5,    1'b1};
      vecs[7] = '{1'b1, 10'd1013, 10'd5,    1'b0};
      vecs[8] = '{1'b1, 10'd0,    10'd1023, 1'b0};

      RESETn      = 1'b0;
      LINE_START  = 1'b0;
      LINE_Y      = '0;
      LIST_RD_IDX = '0;
      clearTable();
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("rst_addr",  32'(SPRITE_TABLE_RD_ADDR), 32'd0);
      checkOutput("rst_count", 32'(HIT_COUNT), 32'd0);
      checkOutput("rst_busy",  32'(SCAN_BUSY), 32'd0);
      checkOutput("rst_done",  32'(SCAN_DONE), 32'd0);
      checkOutput("rst_ovf",   32'(OVERFLOW), 32'd0);
      checkOutput("rst_list0", LIST_RD_DATA, 32'd0);
      @(negedge CLK);
      RESETn = 1'b1;

      // Empty table: address walk and done timing.
      applyStimulus(10'd100);
      @(negedge CLK);
      checkOutput("empty_busy_c1", 32'(SCAN_BUSY), 32'd1);
      checkOutput("empty_addr_c1", 32'(SPRITE_TABLE_RD_ADDR), 32'd0);
      for (int c = 2; c <= 70; c++) @(negedge CLK);
      applyStimulus(10'd100);
      waitDone(doneCyc, doneCnt, addrErr);
      checkOutput("empty_addr_walk", 32'(addrErr), 32'd0);
      checkOutput("empty_done_cyc", 32'(doneCyc), 32'd66);
      checkOutput("empty_done_cnt", 32'(doneCnt), 32'd1);
      checkOutput("empty_count", 32'(HIT_COUNT), 32'd0);
      checkOutput("empty_ovf", 32'(OVERFLOW), 32'd0);
      checkOutput("empty_busy_after", 32'(SCAN_BUSY), 32'd0);

      // Mixed entries for line 100.
      clearTable();
      mem[3]  = mk(1'b1, 7'd3,  10'd30,  10'd95,  4'd1);
      mem[10] = mk(1'b1, 7'd10, 10'd100, 10'd100, 4'd2);
      mem[20] = mk(1'b1, 7'd20, 10'd200, 10'd101, 4'd3);
      mem[30] = mk(1'b0, 7'd30, 10'd300, 10'd90,  4'd4);
      applyStimulus(10'd100);
      waitDone(doneCyc, doneCnt, addrErr);
      checkOutput("mix_count", 32'(HIT_COUNT), 32'd2);
      readEntry(0, d);
      checkOutput("mix_list0", d, mk(1'b1, 7'd3, 10'd30, 10'd95, 4'd1));
      readEntry(1, d);
      checkOutput("mix_list1", d, mk(1'b1, 7'd10, 10'd100, 10'd100, 4'd2));

      // Single-entry hit test vectors.
      for (int v = 0; v < 9; v++) begin
         clearTable();
         mem[5] = mk(vecs[v].en, 7'(v), 10'(v * 7), vecs[v].y, 4'(v));
         applyStimulus(vecs[v].line);
         waitDone(doneCyc, doneCnt, addrErr);
         checkOutput($sformatf("vec%0d_count", v), 32'(HIT_COUNT), 32'(vecs[v].hit));
         if (vecs[v].hit) begin
            readEntry(0, d);
            checkOutput($sformatf("vec%0d_list0", v), d,
                        mk(vecs[v].en, 7'(v), 10'(v * 7), vecs[v].y, 4'(v)));
         end
      end

      // Ten hits: list fills at eight, entry 8 overflows and ends the scan early.
      clearTable();
      for (int i = 0; i < 10; i++) mem[i] = mk(1'b1, 7'(i + 1), 10'(i), 10'd100, 4'(i));
      applyStimulus(10'd100);
      waitDone(doneCyc, doneCnt, addrErr);
      checkOutput("ovf_done_cyc", 32'(doneCyc), 32'd11);
      checkOutput("ovf_done_cnt", 32'(doneCnt), 32'd1);
      checkOutput("ovf_count", 32'(HIT_COUNT), 32'd8);
      checkOutput("ovf_flag", 32'(OVERFLOW), 32'd1);
      readEntry(0, d);
      checkOutput("ovf_list0", d, mk(1'b1, 7'd1, 10'd0, 10'd100, 4'd0));
      readEntry(7, d);
      checkOutput("ovf_list7", d, mk(1'b1, 7'd8, 10'd7, 10'd100, 4'd7));

      // Restart mid-scan with a different line.
      clearTable();
      mem[2]  = mk(1'b1, 7'd2,  10'd2,  10'd100, 4'd2);
      mem[40] = mk(1'b1, 7'd40, 10'd40, 10'd195, 4'd5);
      mem[50] = mk(1'b1, 7'd50, 10'd50, 10'd200, 4'd6);
      applyStimulus(10'd100);
      checkOutput("restart_ovf_cleared", 32'(OVERFLOW), 32'd0);
      doneCnt = 0;
      for (int c = 1; c <= 19; c++) begin
         @(negedge CLK);
         if (SCAN_DONE === 1'b1) doneCnt++;
      end
      checkOutput("restart_no_early_done", 32'(doneCnt), 32'd0);
      applyStimulus(10'd200);
      waitDone(doneCyc, doneCnt, addrErr);
      checkOutput("restart_addr_walk", 32'(addrErr), 32'd0);
      checkOutput("restart_done_cyc", 32'(doneCyc), 32'd66);
      checkOutput("restart_done_cnt", 32'(doneCnt), 32'd1);
      checkOutput("restart_count", 32'(HIT_COUNT), 32'd2);
      readEntry(0, d);
      checkOutput("restart_list0", d, mk(1'b1, 7'd40, 10'd40, 10'd195, 4'd5));
      readEntry(1, d);
      checkOutput("restart_list1", d, mk(1'b1, 7'd50, 10'd50, 10'd200, 4'd6));

`ifdef SPRITE_LIST_DBL_BUF_EN
      // Front bank holds the line-200 results while line 300 is scanned.
      clearTable();
      mem[5] = mk(1'b1, 7'd99, 10'd9, 10'd300, 4'd9);
      applyStimulus(10'd300);
      for (int c = 1; c <= 30; c++) @(negedge CLK);
      checkOutput("dbl_count_hold", 32'(HIT_COUNT), 32'd2);
      readEntry(0, d);
      checkOutput("dbl_list0_hold", d, mk(1'b1, 7'd40, 10'd40, 10'd195, 4'd5));
      for (int c = 31; c <= 65; c++) @(negedge CLK);
      checkOutput("dbl_count_before_done", 32'(HIT_COUNT), 32'd2);
      @(negedge CLK);
      checkOutput("dbl_done_cycle", 32'(SCAN_DONE), 32'd1);
      checkOutput("dbl_count_swap", 32'(HIT_COUNT), 32'd1);
      readEntry(0, d);
      checkOutput("dbl_list0_swap", d, mk(1'b1, 7'd99, 10'd9, 10'd300, 4'd9));
`endif

      // Asynchronous reset mid-scan.
      clearTable();
      mem[1] = mk(1'b1, 7'd1, 10'd1, 10'd50, 4'd1);
      applyStimulus(10'd50);
      for (int c = 1; c <= 10; c++) @(negedge CLK);
      LIST_RD_IDX = 3'd0;
      #2 RESETn = 1'b0;
      #1;
      checkOutput("arst_busy",  32'(SCAN_BUSY), 32'd0);
      checkOutput("arst_addr",  32'(SPRITE_TABLE_RD_ADDR), 32'd0);
      checkOutput("arst_count", 32'(HIT_COUNT), 32'd0);
      checkOutput("arst_list0", LIST_RD_DATA, 32'd0);
      checkOutput("arst_ovf",   32'(OVERFLOW), 32'd0);
      @(negedge CLK);
      RESETn = 1'b1;
      repeat (2) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_table_scanner.md
Name: sprite_table_scanner

Overview:
- Read-side counterpart of the CPU-to-sprite-table write path.
- On each line-start pulse, walks the sprite table through the RAM's synchronous read port and finds the sprites whose vertical extent covers the requested scanline.
- Copies up to MAX_PER_LINE hit entries into a small per-line list, which the pixel renderer indexes during the active line.
- Sits in the video block between the sprite table RAM (port B) and the sprite renderer.

Parameters:
- NUM_SPRITES, 64, number of table entries scanned (word addresses 0..NUM_SPRITES-1, max 512).
- SPRITE_H, 16, sprite height in lines.
- MAX_PER_LINE, 8, capacity of the per-line hit list.

Ports:
- CLK  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- LINE_START  in  1  one-cycle pulse: start scanning for LINE_Y
- LINE_Y  in  10  target scanline, sampled when LINE_START=1
- SPRITE_TABLE_RD_ADDR  out  9  table read address
- SPRITE_TABLE_DO  in  32  table read data, valid 1 cycle after address
- LIST_RD_IDX  in  $clog2(MAX_PER_LINE)  renderer list index
- LIST_RD_DATA  out  32  list entry at LIST_RD_IDX (combinational read)
- HIT_COUNT  out  $clog2(MAX_PER_LINE+1)  valid list entries
- SCAN_BUSY  out  1  scan in progress
- SCAN_DONE  out  1  one-cycle pulse at scan end
- OVERFLOW  out  1  more than MAX_PER_LINE hits on last scan

Behaviour:
- Entry format (32 bits):
  - [31] enable
  - [30:24] image id
  - [23:14] x
  - [13:4] y
  - [3:0] palette
- Hit test: enable=1 AND ((LINE_Y_latched - y) mod 1024) < SPRITE_H. Uses 10-bit wrap subtraction, so sprites with y near 1023 wrap to line 0.
- Reset values: SPRITE_TABLE_RD_ADDR=0, HIT_COUNT=0, SCAN_BUSY=0, SCAN_DONE=0, OVERFLOW=0, all list entries=0, FSM=IDLE.
- FSM states: IDLE, READ, LAST, DONE.
  - IDLE: on LINE_START, latch LINE_Y, clear HIT_COUNT and OVERFLOW, set ADDR=0, go to READ.
  - READ: each cycle ADDR++. The entry returned for the previous address is evaluated in the same cycle. When ADDR=NUM_SPRITES-1 has been issued, go to LAST.
  - LAST: evaluate the final entry, then go to DONE.
  - DONE: SCAN_DONE=1 for this one cycle, then IDLE.
- A 1-cycle valid pipe tracks which data beats are real; the first beat after leaving IDLE is discarded.
- Timing (LINE_START sampled at cycle 0):
  - ADDR=i is presented at cycle i+1.
  - Entry i is evaluated at cycle i+2.
  - SCAN_DONE pulses at cycle NUM_SPRITES+2.
- SCAN_BUSY=1 in READ and LAST only.
- On a hit with HIT_COUNT<MAX_PER_LINE: list[HIT_COUNT] <= entry and HIT_COUNT++ (registered).
- Hit-list full: a hit with HIT_COUNT==MAX_PER_LINE sets OVERFLOW, drops the entry, and goes straight to DONE (early termination). SCAN_DONE still pulses once.
- LINE_START while busy: abort, re-latch LINE_Y, clear count and OVERFLOW, restart at ADDR=0. Any in-flight read beat is discarded.
- LINE_START in DONE: SCAN_DONE still pulses, and the new scan starts next cycle as from IDLE.
- OVERFLOW and HIT_COUNT hold until the next LINE_START.
- LIST_RD_DATA:
  - When LIST_RD_IDX >= HIT_COUNT, returns the stale entry; the renderer must gate on HIT_COUNT.
  - Out-of-range index (>= MAX_PER_LINE) returns 0.
- Reset mid-scan returns immediately to the reset state.

Optional Feature:
- Macro: SPRITE_LIST_DBL_BUF_EN.
- Defined:
  - Two list banks plus HIT_COUNT per bank.
  - The scan writes the back bank; LIST_RD_DATA and HIT_COUNT reflect the front bank.
  - The banks swap on the SCAN_DONE cycle, so the renderer sees a stable list for the whole line while the next line is scanned.
  - An aborted scan never swaps.
  - Both banks reset to 0.
- Undefined:
  - Single bank; LIST_RD_DATA/HIT_COUNT update live during the scan.
  - The renderer must read only after SCAN_DONE.

Decomposition:
- Shared package sprite_pkg:
  - sprite_entry_t packed struct (en, img, x, y, pal)
  - SPRITE_Y_W=10
  - SPRITE_TBL_ADDR_W=9
  - scan_state_t enum
- One sub-module: sprite_line_list. Holds the bank storage, write pointer, HIT_COUNT and the double-buffer swap logic, so the FSM only issues write strobes.

Test Plan:
- Reset, then LINE_START, LINE_Y=100, table all zero:
  - ADDR walks 0..63 from cycle 1.
  - SCAN_DONE at cycle 66.
  - HIT_COUNT=0, OVERFLOW=0.
- Entries 3 (y=95), 10 (y=100), 20 (y=101, en=1) and 30 (y=90, en=0); LINE_Y=100:
  - HIT_COUNT=2.
  - list[0]=entry3, list[1]=entry10.
  - Entry 20 (y=101) misses because 100-101 wraps to 1023; entry 30 misses because it is disabled.
- Wrap: entry y=1020, LINE_Y=5 → hit, since diff=9 < 16.
- Ten enabled hits at indexes 0..9:
  - list holds entries 0..7, HIT_COUNT=8.
  - OVERFLOW=1 at entry 8's evaluation; SCAN_DONE the next cycle, before index 63 is read.
- LINE_START again at cycle 20 with LINE_Y=200:
  - ADDR restarts at 0.
  - Only hits for line 200 are listed.
  - Exactly one SCAN_DONE, 66 cycles after the second pulse.
- With SPRITE_LIST_DBL_BUF_EN:
  - During the second scan, LIST_RD_DATA/HIT_COUNT still show the first scan's results.
  - They switch on the SCAN_DONE cycle.
  - RESETn low mid-scan clears all outputs within the same cycle (asynchronous).
